// File: rtl/ntt_perm_pkg.sv
// ntt_perm_pkg: shared sizes, types and index helpers for the stage-3 lane permutation
package ntt_perm_pkg;
    localparam int DATA_WIDTH_PER_INPUT = 28;
    localparam int INPUT_PER_CYCLE = 64;
    localparam int N_POLY = 512;
    localparam int BEATS = N_POLY / INPUT_PER_CYCLE;
    localparam int BEAT_AW = $clog2(BEATS);
    localparam int LANE_AW = $clog2(INPUT_PER_CYCLE);

    typedef logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] lane_vec_t;
    typedef logic [BEAT_AW-1:0] beat_t;
    typedef enum logic {W_IDLE, W_FILL} w_state_t;
    typedef enum logic {R_IDLE, R_PLAY} r_state_t;

    function automatic beat_t bitrev_beat(input beat_t b);
        beat_t r;
        for (int i = 0; i < BEAT_AW; i++) r[i] = b[BEAT_AW-1-i];
        return r;
    endfunction

    function automatic lane_vec_t swap_b0_b4(input lane_vec_t v);
        lane_vec_t r;
        logic [LANE_AW-1:0] s;
        for (int l = 0; l < INPUT_PER_CYCLE; l++) begin
            s = LANE_AW'(l);
            s[0] = s[4] ^ s[0];
            s[4] = s[4] ^ s[0];
            s[0] = s[4] ^ s[0];
            r[l] = v[s];
        end
        return r;
    endfunction
endpackage

// File: rtl/stage_3_inv_permutation_if.sv
// stage_3_inv_permutation_if: frame in/out bus; err_restart exists only with STAGE3_INV_PERM_ERR_EN
interface stage_3_inv_permutation_if;
    import ntt_perm_pkg::*;
    logic in_start;
    lane_vec_t inData;
    logic out_start;
    logic out_valid;
    lane_vec_t outData;
`ifdef STAGE3_INV_PERM_ERR_EN
    logic err_restart;
    modport master (output in_start, inData, input out_start, out_valid, outData, err_restart);
    modport slave (input in_start, inData, output out_start, out_valid, outData, err_restart);
`else
    modport master (output in_start, inData, input out_start, out_valid, outData);
    modport slave (input in_start, inData, output out_start, out_valid, outData);
`endif
endinterface

// File: rtl/perm_pingpong_bank.sv
// perm_pingpong_bank: two BEATS-deep frame banks, one write port and one registered read port
module perm_pingpong_bank
    import ntt_perm_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      we,
    input  logic      wsel,
    input  beat_t     waddr,
    input  lane_vec_t wdata,
    input  logic      re,
    input  logic      rsel,
    input  beat_t     raddr,
    output lane_vec_t rdata
);
    lane_vec_t mem [2][BEATS];

    // write port; stored beats need no reset
    always_ff @(posedge clk)
        if (we) mem[wsel][waddr] <= wdata;

    // registered read port that holds its last value while idle
    always_ff @(posedge clk or negedge rst)
        if (!rst) rdata <= '0;
        else if (re) rdata <= mem[rsel][raddr];
endmodule

// File: rtl/stage_3_inv_permutation.sv
// stage_3_inv_permutation: ping-pong frame buffer replaying beats bit-reversed with lane bits 0/4 swapped; STAGE3_INV_PERM_ERR_EN adds err_restart
module stage_3_inv_permutation
    import ntt_perm_pkg::*;
(
    input logic clk,
    input logic rst,
    stage_3_inv_permutation_if.slave bus
);
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    beat_t wcnt, wcnt_next, rcnt, rcnt_next;
    logic wbank, wbank_next, rbank, rbank_next;
    logic we, frame_ready, restart;
    lane_vec_t rdata;

    // write FSM: fill a bank beat by beat, restart on early in_start, hand off on the last beat
    always_comb begin
        w_next = w_state;
        wcnt_next = wcnt;
        wbank_next = wbank;
        we = 1'b0;
        frame_ready = 1'b0;
        restart = 1'b0;
        if (w_state == W_IDLE) begin
            if (bus.in_start) begin
                we = 1'b1;
                wcnt_next = beat_t'(1);
                w_next = W_FILL;
            end
        end else begin
            we = 1'b1;
            if (wcnt == beat_t'(BEATS-1)) begin
                frame_ready = 1'b1;
                wbank_next = ~wbank;
                wcnt_next = '0;
                w_next = W_IDLE;
            end else if (bus.in_start) begin
                restart = 1'b1;
                wcnt_next = beat_t'(1);
            end else begin
                wcnt_next = wcnt + 1'b1;
            end
        end
    end

    // read FSM: play the bank just filled, chaining straight into the next frame when it is ready
    always_comb begin
        r_next = r_state;
        rcnt_next = rcnt;
        rbank_next = rbank;
        if (frame_ready && (r_state == R_IDLE || rcnt == beat_t'(BEATS-1))) begin
            r_next = R_PLAY;
            rcnt_next = '0;
            rbank_next = wbank;
        end else if (r_state == R_PLAY) begin
            rcnt_next = rcnt + 1'b1;
            r_next = rcnt == beat_t'(BEATS-1) ? R_IDLE : R_PLAY;
        end
    end

    // state, counters, bank selects and output framing flags
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            wcnt <= '0;
            rcnt <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_start <= 1'b0;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
            wcnt <= wcnt_next;
            rcnt <= rcnt_next;
            wbank <= wbank_next;
            rbank <= rbank_next;
            bus.out_valid <= r_state == R_PLAY;
            bus.out_start <= r_state == R_PLAY && rcnt == '0;
        end

`ifdef STAGE3_INV_PERM_ERR_EN
    // sticky flag for a frame restarted before its last beat
    always_ff @(posedge clk or negedge rst)
        if (!rst) bus.err_restart <= 1'b0;
        else if (restart) bus.err_restart <= 1'b1;
`endif

    perm_pingpong_bank u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .wsel  (wbank),
        .waddr (restart ? '0 : wcnt),
        .wdata (bus.inData),
        .re    (r_state == R_PLAY),
        .rsel  (rbank),
        .raddr (bitrev_beat(rcnt)),
        .rdata (rdata)
    );

    assign bus.outData = swap_b0_b4(rdata);
endmodule

// File: tb/tb_stage_3_inv_permutation.sv
// tb_stage_3_inv_permutation: randomized frame bench with a plain-arithmetic permutation model
module tb_stage_3_inv_permutation;
    import ntt_perm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    stage_3_inv_permutation_if intf();
    stage_3_inv_permutation dut (.clk(clk), .rst(rst), .bus(intf));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lane_vec_t oq[$];
    int cq[$];
    logic sq[$];
    lane_vec_t frames [2][BEATS];

    // capture every valid output beat with the cycle it was visible in
    always @(negedge clk)
        if (intf.out_valid) begin
            oq.push_back(intf.outData);
            cq.push_back(cyc);
            sq.push_back(intf.out_start);
        end

    function automatic int brev(input int j);
        return ((j & 1) << 2) | (j & 2) | (j >> 2);
    endfunction

    function automatic int lsw(input int l);
        return (l & ~17) | ((l & 1) << 4) | ((l >> 4) & 1);
    endfunction

    function automatic lane_vec_t expect_beat(input int f, input int j);
        lane_vec_t r;
        for (int l = 0; l < INPUT_PER_CYCLE; l++) r[l] = frames[f][brev(j)][lsw(l)];
        return r;
    endfunction

    function automatic int first_diff(input lane_vec_t a, input lane_vec_t b);
        for (int l = 0; l < INPUT_PER_CYCLE; l++) if (a[l] !== b[l]) return l;
        return 0;
    endfunction

    function automatic lane_vec_t rnd_beat();
        lane_vec_t r;
        for (int l = 0; l < INPUT_PER_CYCLE; l++) r[l] = DATA_WIDTH_PER_INPUT'($urandom);
        return r;
    endfunction

    task automatic step(input logic s, input lane_vec_t d);
        @(posedge clk);
        #1;
        intf.in_start = s;
        intf.inData = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, rnd_beat());
    endtask

    task automatic send(input int f, output int t0);
        step(1'b1, frames[f][0]);
        t0 = cyc;
        for (int b = 1; b < BEATS; b++) step(1'b0, frames[f][b]);
    endtask

    task automatic rnd_frame(input int f);
        for (int b = 0; b < BEATS; b++) frames[f][b] = rnd_beat();
    endtask

    task automatic clear_q();
        oq.delete();
        cq.delete();
        sq.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (intf.out_valid !== 1'b0 || intf.out_start !== 1'b0 || intf.outData !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b start=%b exp 0/0 with zero data", intf.out_valid, intf.out_start);
        end
`ifdef STAGE3_INV_PERM_ERR_EN
        total++;
        if (intf.err_restart !== 1'b0) begin
            bad++;
            $display("FAIL reset_err got=%b exp=0", intf.err_restart);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, rnd_beat());
            @(negedge clk);
            total++;
            if (intf.out_valid !== 1'b0 || intf.outData !== '0) begin
                bad++;
                $display("FAIL idle_quiet cycle=%0d got valid=%b exp valid=0 with zero data", i, intf.out_valid);
            end
        end
    endtask

    task automatic test_single_frame();
        int t0;
        lane_vec_t b1, e;
        for (int b = 0; b < BEATS; b++)
            for (int l = 0; l < INPUT_PER_CYCLE; l++) frames[0][b][l] = DATA_WIDTH_PER_INPUT'(b * 64 + l);
        clear_q();
        send(0, t0);
        idle(12);
        total++;
        if (oq.size() !== BEATS) begin
            bad++;
            $display("FAIL single_count got=%0d exp=%0d", oq.size(), BEATS);
        end
        for (int j = 0; j < oq.size(); j++) begin
            e = expect_beat(0, j);
            total++;
            if (cq[j] !== t0 + 9 + j || sq[j] !== (j == 0)) begin
                bad++;
                $display("FAIL single_timing beat=%0d got cycle=%0d start=%b exp cycle=%0d start=%b", j, cq[j] - t0, sq[j], 9 + j, j == 0);
            end
            total++;
            if (oq[j] !== e) begin
                bad++;
                $display("FAIL single_data beat=%0d lane=%0d got=%0d exp=%0d", j, first_diff(oq[j], e), oq[j][first_diff(oq[j], e)], e[first_diff(oq[j], e)]);
            end
        end
        if (oq.size() > 1) begin
            b1 = oq[1];
            total++;
            if (b1[1] !== 28'd272) begin
                bad++;
                $display("FAIL single_b1_l1 got=%0d exp=272", b1[1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, t;
        lane_vec_t fr [3][BEATS];
        lane_vec_t e;
        for (int f = 0; f < 3; f++)
            for (int b = 0; b < BEATS; b++) fr[f][b] = rnd_beat();
        clear_q();
        frames[0] = fr[0];
        send(0, t0);
        frames[1] = fr[1];
        send(1, t);
        frames[0] = fr[2];
        send(0, t);
        idle(12);
        total++;
        if (oq.size() !== 3 * BEATS) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=%0d", oq.size(), 3 * BEATS);
        end
        for (int k = 0; k < oq.size(); k++) begin
            frames[0] = fr[k / BEATS];
            e = expect_beat(0, k % BEATS);
            total++;
            if (cq[k] !== t0 + 9 + k || sq[k] !== (k % BEATS == 0)) begin
                bad++;
                $display("FAIL b2b_timing beat=%0d got cycle=%0d start=%b exp cycle=%0d start=%b", k, cq[k] - t0, sq[k], 9 + k, k % BEATS == 0);
            end
            total++;
            if (oq[k] !== e) begin
                bad++;
                $display("FAIL b2b_data beat=%0d lane=%0d got=%0d exp=%0d", k, first_diff(oq[k], e), oq[k][first_diff(oq[k], e)], e[first_diff(oq[k], e)]);
            end
        end
    endtask

    task automatic test_restart();
        int t0;
        lane_vec_t e;
        rnd_frame(0);
        clear_q();
        step(1'b1, rnd_beat());
        t0 = cyc;
        step(1'b0, rnd_beat());
        step(1'b0, rnd_beat());
        step(1'b1, frames[0][0]);
`ifdef STAGE3_INV_PERM_ERR_EN
        @(negedge clk);
        total++;
        if (intf.err_restart !== 1'b0) begin
            bad++;
            $display("FAIL restart_err_early got=%b exp=0", intf.err_restart);
        end
`endif
        step(1'b0, frames[0][1]);
`ifdef STAGE3_INV_PERM_ERR_EN
        @(negedge clk);
        total++;
        if (intf.err_restart !== 1'b1) begin
            bad++;
            $display("FAIL restart_err_set got=%b exp=1", intf.err_restart);
        end
`endif
        for (int b = 2; b < BEATS; b++) step(1'b0, frames[0][b]);
        idle(12);
        total++;
        if (oq.size() !== BEATS) begin
            bad++;
            $display("FAIL restart_count got=%0d exp=%0d", oq.size(), BEATS);
        end
        for (int j = 0; j < oq.size(); j++) begin
            e = expect_beat(0, j);
            total++;
            if (cq[j] !== t0 + 12 + j || sq[j] !== (j == 0)) begin
                bad++;
                $display("FAIL restart_timing beat=%0d got cycle=%0d start=%b exp cycle=%0d start=%b", j, cq[j] - t0, sq[j], 12 + j, j == 0);
            end
            total++;
            if (oq[j] !== e) begin
                bad++;
                $display("FAIL restart_data beat=%0d lane=%0d got=%0d exp=%0d", j, first_diff(oq[j], e), oq[j][first_diff(oq[j], e)], e[first_diff(oq[j], e)]);
            end
        end
`ifdef STAGE3_INV_PERM_ERR_EN
        total++;
        if (intf.err_restart !== 1'b1) begin
            bad++;
            $display("FAIL restart_err_sticky got=%b exp=1", intf.err_restart);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int t0;
        lane_vec_t e;
        rnd_frame(0);
        send(0, t0);
        idle(5);
        total++;
        if (intf.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_playing got valid=%b exp=1 at cycle %0d", intf.out_valid, cyc - t0);
        end
        rst = 1'b0;
        #1;
        total++;
        if (intf.out_valid !== 1'b0 || intf.out_start !== 1'b0 || intf.outData !== '0) begin
            bad++;
            $display("FAIL mid_async_clear got valid=%b start=%b exp 0/0 with zero data", intf.out_valid, intf.out_start);
        end
`ifdef STAGE3_INV_PERM_ERR_EN
        total++;
        if (intf.err_restart !== 1'b0) begin
            bad++;
            $display("FAIL mid_err_clear got=%b exp=0", intf.err_restart);
        end
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_q();
        idle(20);
        total++;
        if (oq.size() !== 0) begin
            bad++;
            $display("FAIL mid_residual got=%0d beats exp=0", oq.size());
        end
        rnd_frame(0);
        send(0, t0);
        idle(12);
        total++;
        if (oq.size() !== BEATS) begin
            bad++;
            $display("FAIL mid_after_count got=%0d exp=%0d", oq.size(), BEATS);
        end
        for (int j = 0; j < oq.size(); j++) begin
            e = expect_beat(0, j);
            total++;
            if (oq[j] !== e || cq[j] !== t0 + 9 + j) begin
                bad++;
                $display("FAIL mid_after_data beat=%0d got cycle=%0d lane%0d=%0d exp cycle=%0d value=%0d", j, cq[j] - t0, first_diff(oq[j], e), oq[j][first_diff(oq[j], e)], 9 + j, e[first_diff(oq[j], e)]);
            end
        end
    endtask

    task automatic test_round_trip();
        int t;
        lane_vec_t orig [BEATS];
        rnd_frame(0);
        for (int b = 0; b < BEATS; b++) orig[b] = frames[0][b];
        clear_q();
        send(0, t);
        idle(12);
        total++;
        if (oq.size() !== BEATS) begin
            bad++;
            $display("FAIL trip_first_count got=%0d exp=%0d", oq.size(), BEATS);
        end
        for (int b = 0; b < BEATS; b++) frames[1][b] = b < oq.size() ? oq[b] : '0;
        clear_q();
        send(1, t);
        idle(12);
        total++;
        if (oq.size() !== BEATS) begin
            bad++;
            $display("FAIL trip_second_count got=%0d exp=%0d", oq.size(), BEATS);
        end
        for (int j = 0; j < oq.size(); j++) begin
            total++;
            if (oq[j] !== orig[j]) begin
                bad++;
                $display("FAIL trip_restore beat=%0d lane=%0d got=%0d exp=%0d", j, first_diff(oq[j], orig[j]), oq[j][first_diff(oq[j], orig[j])], orig[j][first_diff(oq[j], orig[j])]);
            end
        end
    endtask

    initial begin
        intf.in_start = 1'b0;
        intf.inData = '0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        test_round_trip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
